// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller:
// opcodes, functs, ALU codes, control bundle and md FSM states.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_NOR = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;

   typedef enum logic {IDLE, BUSY} md_state_t;

   typedef struct packed {
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
      logic [3:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/pipe_controller_if.sv
// Decode inputs and per-stage control outputs of the controller.
interface pipe_controller_if #(
   parameter int ALUCTL_W = 4
);
   logic [5:0]          opD;
   logic [5:0]          functD;
   logic                equalD;
   logic                flushE;
   logic                stallE;
   logic                pcsrcD;
   logic                branchD;
   logic                jumpD;
   logic                immextD;
   logic                illegalD;
   logic                memtoregE;
   logic                alusrcE;
   logic                regdstE;
   logic                regwriteE;
   logic [ALUCTL_W-1:0] alucontrolE;
   logic                md_startE;
   logic                md_busy;
   logic                md_stallD;
   logic                memtoregM;
   logic                memwriteM;
   logic                regwriteM;
   logic                memtoregW;
   logic                regwriteW;

   modport master (
      output opD, functD, equalD, flushE, stallE,
      input  pcsrcD, branchD, jumpD, immextD, illegalD,
      input  memtoregE, alusrcE, regdstE, regwriteE,
      input  alucontrolE, md_startE, md_busy, md_stallD,
      input  memtoregM, memwriteM, regwriteM,
      input  memtoregW, regwriteW
   );

   modport slave (
      input  opD, functD, equalD, flushE, stallE,
      output pcsrcD, branchD, jumpD, immextD, illegalD,
      output memtoregE, alusrcE, regdstE, regwriteE,
      output alucontrolE, md_startE, md_busy, md_stallD,
      output memtoregM, memwriteM, regwriteM,
      output memtoregW, regwriteW
   );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational main/ALU decoder for the instruction in Decode.
module ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       equal,
   output ctrl_t      ctrl,
   output logic       md_op,
   output logic       mult_op,
   output logic       branch,
   output logic       jump,
   output logic       immext,
   output logic       illegal,
   output logic       pcsrc
);
   logic bne_op;

   always_comb begin
      ctrl    = '0;
      md_op   = 1'b0;
      mult_op = 1'b0;
      branch  = 1'b0;
      jump    = 1'b0;
      immext  = 1'b0;
      illegal = 1'b0;
      bne_op  = 1'b0;
      unique case (1'b1)
         (op == OP_RTYPE): begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
            unique case (1'b1)
               (funct == FN_ADD): ctrl.aluop = ALU_ADD;
               (funct == FN_SUB): ctrl.aluop = ALU_SUB;
               (funct == FN_AND): ctrl.aluop = ALU_AND;
               (funct == FN_OR):  ctrl.aluop = ALU_OR;
               (funct == FN_XOR): ctrl.aluop = ALU_XOR;
               (funct == FN_NOR): ctrl.aluop = ALU_NOR;
               (funct == FN_SLT): ctrl.aluop = ALU_SLT;
               (funct == FN_SLL): ctrl.aluop = ALU_SLL;
               (funct == FN_SRL): ctrl.aluop = ALU_SRL;
               (funct == FN_MULT),
               (funct == FN_MULTU): begin
                  // results go to hi/lo, never the register file
                  ctrl    = '0;
                  md_op   = 1'b1;
                  mult_op = 1'b1;
               end
               (funct == FN_MFHI),
               (funct == FN_MFLO): md_op = 1'b1;
               default: begin
                  ctrl    = '0;
                  illegal = 1'b1;
               end
            endcase
         end
         (op == OP_LW): begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.aluop    = ALU_ADD;
         end
         (op == OP_SW): begin
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.aluop    = ALU_ADD;
         end
         (op == OP_BEQ), (op == OP_BNE): begin
            branch     = 1'b1;
            bne_op     = op[0];
            ctrl.aluop = ALU_SUB;
         end
         (op == OP_ADDI): begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.aluop    = ALU_ADD;
         end
         (op == OP_ANDI): begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.aluop    = ALU_AND;
            immext        = 1'b1;
         end
         (op == OP_ORI): begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.aluop    = ALU_OR;
            immext        = 1'b1;
         end
         (op == OP_SLTI): begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.aluop    = ALU_SLT;
         end
         (op == OP_J): jump = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

   assign pcsrc = branch & (equal ^ bne_op);

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: decode, D/E, E/M, M/W control
// registers and the multiply/divide busy tracker.
module pipe_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int ALUCTL_W = 4,
   parameter int MD_LAT   = 4
) (
   input logic               clk,
   input logic               reset,
   pipe_controller_if.slave  bus
);
   localparam logic [3:0] LAT0 = 4'(MD_LAT - 1);

   ctrl_t     d_c;
   ctrl_t     e_q;
   logic      md_op;
   logic      mult_op;
   logic      md_go;
   logic      m_memtoreg, m_memwrite, m_regwrite;
   logic      w_memtoreg, w_regwrite;
   md_state_t state;
   logic [3:0] cnt;
   logic      start_q;
   logic      busy_q;

   ctrl_decode u_dec (
      .op      (bus.opD),
      .funct   (bus.functD),
      .equal   (bus.equalD),
      .ctrl    (d_c),
      .md_op   (md_op),
      .mult_op (mult_op),
      .branch  (bus.branchD),
      .jump    (bus.jumpD),
      .immext  (bus.immextD),
      .illegal (bus.illegalD),
      .pcsrc   (bus.pcsrcD)
   );

   assign md_go = mult_op & ~bus.flushE & ~bus.stallE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          e_q <= '0;
      else if (bus.flushE) e_q <= '0;
      else if (!bus.stallE) e_q <= d_c;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_memtoreg <= 1'b0;
         m_memwrite <= 1'b0;
         m_regwrite <= 1'b0;
         w_memtoreg <= 1'b0;
         w_regwrite <= 1'b0;
      end else begin
         // a held Execute must not issue twice into Memory
         m_memtoreg <= e_q.memtoreg & ~(bus.stallE | bus.flushE);
         m_memwrite <= e_q.memwrite & ~(bus.stallE | bus.flushE);
         m_regwrite <= e_q.regwrite & ~(bus.stallE | bus.flushE);
         w_memtoreg <= m_memtoreg;
         w_regwrite <= m_regwrite;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         start_q <= md_go;
         if (md_go) begin
            state  <= BUSY;
            cnt    <= LAT0;
            busy_q <= 1'b1;
         end else begin
            case (state)
               IDLE: busy_q <= 1'b0;
               BUSY: begin
                  if (cnt == 4'd0) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.memtoregE   = e_q.memtoreg;
   assign bus.alusrcE     = e_q.alusrc;
   assign bus.regdstE     = e_q.regdst;
   assign bus.regwriteE   = e_q.regwrite;
   assign bus.alucontrolE = ALUCTL_W'(e_q.aluop);
   assign bus.md_startE   = start_q;
   assign bus.md_busy     = busy_q;
   // a single-cycle unit finishes in its start cycle
   assign bus.md_stallD   = md_op & busy_q & ((MD_LAT > 1) | ~start_q);
   assign bus.memtoregM   = m_memtoreg;
   assign bus.memwriteM   = m_memwrite;
   assign bus.regwriteM   = m_regwrite;
   assign bus.memtoregW   = w_memtoreg;
   assign bus.regwriteW   = w_regwrite;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller with MD_LAT=4.
module tb_pipe_controller;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   pipe_controller_if #(.ALUCTL_W(4)) bus ();

   pipe_controller #(.ALUCTL_W(4), .MD_LAT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                        input logic eq, input logic fl, input logic st);
      bus.opD    = op;
      bus.functD = fn;
      bus.equalD = eq;
      bus.flushE = fl;
      bus.stallE = st;
      #1;
   endtask

   function automatic logic [7:0] e_vec();
      return {bus.memtoregE, bus.alusrcE, bus.regdstE,
              bus.regwriteE, bus.alucontrolE};
   endfunction

   function automatic logic [7:0] mw_vec();
      return {3'b000, bus.memtoregM, bus.memwriteM, bus.regwriteM,
              bus.memtoregW, bus.regwriteW};
   endfunction

   initial begin
      drive(6'b001100, 6'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("rst_E", e_vec(), 8'h00);
      chk("rst_MW", mw_vec(), 8'h00);
      chk("rst_busy", {bus.md_busy, bus.md_startE}, 8'h00);
      chk("rst_andi_immext", bus.immextD, 8'h01);

      reset = 1'b1;
      drive(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
      tick();
      // memtoreg,alusrc,regdst,regwrite,alu
      chk("lw_E", e_vec(), 8'b1101_0010);
      drive(6'b111111, 6'd0, 1'b0, 1'b0, 1'b0);
      chk("illegal_op", bus.illegalD, 8'h01);
      tick();
      chk("illegal_E", e_vec(), 8'h00);
      chk("lw_M", mw_vec(), 8'b000_10100);
      tick();
      chk("lw_W", mw_vec(), 8'b000_00011);

      drive(6'b000101, 6'd0, 1'b0, 1'b0, 1'b0);
      chk("bne_ne", {bus.branchD, bus.pcsrcD}, 8'h03);
      drive(6'b000101, 6'd0, 1'b1, 1'b0, 1'b0);
      chk("bne_eq", {bus.branchD, bus.pcsrcD}, 8'h02);
      drive(6'b000100, 6'd0, 1'b0, 1'b0, 1'b0);
      chk("beq_ne", {bus.branchD, bus.pcsrcD}, 8'h02);
      drive(6'b000100, 6'd0, 1'b1, 1'b0, 1'b0);
      chk("beq_eq", {bus.branchD, bus.pcsrcD}, 8'h03);
      drive(6'b000010, 6'd0, 1'b0, 1'b0, 1'b0);
      chk("j", {bus.jumpD, bus.branchD, bus.illegalD}, 8'h04);
      drive(6'b000000, 6'b111111, 1'b0, 1'b0, 1'b0);
      chk("bad_funct", bus.illegalD, 8'h01);
      tick();
      chk("bad_funct_E", e_vec(), 8'h00);

      drive(6'b001101, 6'd0, 1'b0, 1'b0, 1'b0);
      chk("ori_immext", bus.immextD, 8'h01);
      tick();
      chk("ori_E", e_vec(), 8'b0101_0001);
      drive(6'b000000, 6'b100110, 1'b0, 1'b0, 1'b0);
      tick();
      chk("xor_E", e_vec(), 8'b0011_0011);
      drive(6'b000000, 6'b100111, 1'b0, 1'b0, 1'b0);
      tick();
      chk("nor_E", e_vec(), 8'b0011_0100);
      drive(6'b000000, 6'b000010, 1'b0, 1'b0, 1'b0);
      tick();
      chk("srl_E", e_vec(), 8'b0011_1001);
      drive(6'b000101, 6'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("bne_E", e_vec(), 8'b0000_0110);
      drive(6'b001010, 6'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("slti_E", e_vec(), 8'b0101_0111);

      drive(6'b001000, 6'd0, 1'b0, 1'b0, 1'b0);
      chk("addi_immext", bus.immextD, 8'h00);
      tick();
      drive(6'b100011, 6'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("stall_hold_E", e_vec(), 8'b0101_0010);
      chk("stall_bubble_M", mw_vec() & 8'h1c, 8'h00);
      drive(6'b100011, 6'd0, 1'b0, 1'b1, 1'b1);
      tick();
      chk("flush_stall_E", e_vec(), 8'h00);

      drive(6'b000000, 6'b011000, 1'b0, 1'b0, 1'b0);
      chk("mult_stallD_idle", bus.md_stallD, 8'h00);
      tick();
      chk("mult_c1", {bus.md_startE, bus.md_busy, bus.regwriteE}, 8'h06);
      drive(6'b000000, 6'b010010, 1'b0, 1'b0, 1'b0);
      chk("mflo_stallD_c1", bus.md_stallD, 8'h01);
      tick();
      chk("mult_c2", {bus.md_startE, bus.md_busy}, 8'h01);
      chk("mflo_stallD_c2", bus.md_stallD, 8'h01);
      tick();
      chk("mult_c3", {bus.md_startE, bus.md_busy}, 8'h01);
      tick();
      chk("mult_c4", {bus.md_startE, bus.md_busy}, 8'h01);
      tick();
      chk("mult_done", {bus.md_startE, bus.md_busy}, 8'h00);
      chk("mflo_stallD_done", bus.md_stallD, 8'h00);

      drive(6'b000000, 6'b011001, 1'b0, 1'b0, 1'b0);
      tick();
      drive(6'b000000, 6'b010010, 1'b0, 1'b0, 1'b0);
      tick();
      chk("multu_busy_c2", {bus.md_startE, bus.md_busy}, 8'h01);
      chk("mflo_E_pre_rst", bus.regwriteE, 8'h01);
      reset = 1'b0;
      #1;
      chk("midop_rst_busy", {bus.md_startE, bus.md_busy}, 8'h00);
      chk("midop_rst_E", e_vec(), 8'h00);
      chk("midop_rst_MW", mw_vec(), 8'h00);
      #2;
      reset = 1'b1;
      #1;
      chk("post_rst_stallD", bus.md_stallD, 8'h00);
      tick();
      chk("post_rst_idle", bus.md_busy, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter ALUCTL_W, default 4, ALU control width; SHALL be at least 4.
REQ-002 Parameter MD_LAT, default 4, multiply/divide unit latency in cycles; legal range 1..16.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 opD, functD  in  6 each  opcode and funct of the instruction in Decode.
REQ-006 equalD  in  1  register-compare result from Decode.
REQ-007 flushE, stallE  in  1 each  hazard-unit flush and stall of the Execute control register.
REQ-008 pcsrcD, branchD, jumpD, immextD, illegalD  out  1 each  Decode-stage controls; immextD is 1 for zero-extend.
REQ-009 memtoregE, alusrcE, regdstE, regwriteE  out  1 each  Execute controls.
REQ-010 alucontrolE  out  ALUCTL_W  Execute ALU operation.
REQ-011 md_startE  out  1  one-cycle start pulse to the multiply/divide unit.
REQ-012 md_busy, md_stallD  out  1 each  multiply/divide busy and Decode stall request.
REQ-013 memtoregM, memwriteM, regwriteM, memtoregW, regwriteW  out  1 each  Memory and Writeback controls.

Function
REQ-014 Decode SHALL be combinational: R-type (op 000000) add, sub, and, or, xor, nor, slt, sll, srl, mult, multu, mfhi, mflo; plus lw, sw, beq, bne, addi, andi, ori, slti, j.
REQ-015 andi/ori SHALL set immextD=1; all other immediates SHALL set immextD=0.
REQ-016 pcsrcD SHALL equal (beq & equalD) | (bne & ~equalD); branchD SHALL be high for beq and bne.
REQ-017 An unlisted op or funct SHALL decode as an all-zero bubble with illegalD=1.
REQ-018 ALU codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110, SLT 0111, SLL 1000, SRL 1001; lw/sw/addi use ADD, beq/bne use SUB; codes are zero-extended to ALUCTL_W.
REQ-019 D->E register: flushE loads zeros; otherwise stallE holds; otherwise loads Decode controls; flushE has priority over stallE.
REQ-020 E->M register SHALL load a bubble (all zeros) when stallE=1 or flushE=1, otherwise Execute controls.
REQ-021 M->W register SHALL load every cycle.
REQ-022 Multiply/divide FSM states are IDLE and BUSY.
REQ-023 A mult/multu entering E (E register loading, not flushed) SHALL pulse md_startE for exactly one cycle, load the counter with MD_LAT-1, and enter BUSY.
REQ-024 md_busy SHALL be high in BUSY; the counter decrements each cycle; at count 0, BUSY SHALL return to IDLE on the next edge.
REQ-025 md_stallD SHALL be high when md_busy=1 and D holds mult, multu, mfhi or mflo; a start in E with MD_LAT>1 counts as busy.
REQ-026 mult/multu SHALL not assert regwriteE.

Reset
REQ-027 reset low SHALL immediately zero all pipeline-register outputs, set md_startE=0 and md_busy=0, and force the FSM to IDLE with counter 0, including mid-operation.
REQ-028 Decode outputs SHALL depend only on inputs, never on reset.

Structure
REQ-029 ALU codes, opcode/funct constants and the FSM state enum SHALL live in shared package pipe_ctrl_pkg.
REQ-030 Decoding SHALL live in one sub-module, ctrl_decode; pipeline registers and FSM stay in pipe_controller.

Verification
REQ-031 lw (op 100011) in D, no stall -> next cycle alusrcE=1, memtoregE=1, regwriteE=1, alucontrolE=0010; memtoregW=1 two cycles later.
REQ-032 bne with equalD=0 -> pcsrcD=1; equalD=1 -> pcsrcD=0; beq gives the opposite values.
REQ-033 Decode sets flushE=1 and stallE=1 together -> E outputs all zero next cycle; stallE=1 alone -> E holds and M receives a bubble.
REQ-034 MD_LAT=4, mult enters E -> md_startE high for 1 cycle, md_busy high 4 cycles; mflo in D during that window -> md_stallD=1.
REQ-035 reset pulsed low in the 2nd BUSY cycle -> md_busy=0 and all E/M/W outputs 0 immediately; after release, mflo in D -> md_stallD=0.
REQ-036 op 111111 -> illegalD=1; E controls all zero next cycle.
